axi_response_slice: RTL and testbench

// - Full-throughput 2-entry register slice on the R and B response channels.
// - Sits directly downstream of the per-target response block, between its rid_o/bid_o outputs and the target (slave) port.
// - Breaks every combinational path: valid, payload and ready are all driven from flops.
// - Also reports buffer occupancy and a count of completed read bursts for debug.

---
 rtl/axi_response_slice.sv | 189 ++++++++++++++++++
 tb/tb_axi_response_slice.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_response_slice.sv
// Two-entry, full-throughput register slice for the AXI R and B response
// channels. Valid, ready and payload toward both sides come straight from
// flops. Also reports per-channel occupancy and a count of completed read
// bursts.

// Generic 2-entry main/skid buffer: the head always sits in main_q, and the
// second entry waits in skid_q.
module axi_response_slice_fifo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   level
);

    logic [W-1:0] main_q;
    logic [W-1:0] main_d;
    logic [W-1:0] skid_q;
    logic [W-1:0] skid_d;
    logic [1:0]   level_q;
    logic [1:0]   level_d;
    logic         valid_q;
    logic         valid_d;
    logic         ready_q;
    logic         ready_d;
    logic         push;
    logic         pop;

    // Next-state: level update and FIFO-ordered placement of the new beat
    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        level_d = level_q;
        push    = in_valid & ready_q;
        pop     = valid_q & out_ready;

        case ({push, pop})
            2'b10: begin
                level_d = level_q + 2'd1;
                if (level_q == 2'd0) begin
                    main_d = in_data;
                end else begin
                    skid_d = in_data;
                end
            end
            2'b01: begin
                level_d = level_q - 2'd1;
                if (level_q == 2'd2) begin
                    main_d = skid_q;
                end
            end
            2'b11: begin
                // Only possible at level 1: old head leaves, new beat becomes head
                main_d = in_data;
            end
            default: begin
            end
        endcase

        valid_d = (level_d != 2'd0);
        ready_d = (level_d != 2'd2);
    end

    // State registers; valid/ready are pre-decoded so outputs are pure flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            skid_q  <= '0;
            level_q <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            level_q <= level_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign level     = level_q;

endmodule

module axi_response_slice #(
    parameter int unsigned AXI_DATA_W = 64,
    parameter int unsigned AXI_ID_IN  = 16,
    parameter int unsigned AXI_USER_W = 6,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [AXI_ID_IN-1:0]  rid_i,
    input  logic [AXI_DATA_W-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic [AXI_USER_W-1:0] ruser_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,

    input  logic [AXI_ID_IN-1:0]  bid_i,
    input  logic [1:0]            bresp_i,
    input  logic [AXI_USER_W-1:0] buser_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,

    output logic [AXI_ID_IN-1:0]  rid_o,
    output logic [AXI_DATA_W-1:0] rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  rlast_o,
    output logic [AXI_USER_W-1:0] ruser_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,

    output logic [AXI_ID_IN-1:0]  bid_o,
    output logic [1:0]            bresp_o,
    output logic [AXI_USER_W-1:0] buser_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,

    output logic [1:0]            r_level_o,
    output logic [1:0]            b_level_o,
    output logic [CNT_W-1:0]      r_bursts_o
);

    localparam int unsigned R_W = AXI_ID_IN + AXI_DATA_W + 2 + 1 + AXI_USER_W;
    localparam int unsigned B_W = AXI_ID_IN + 2 + AXI_USER_W;

    logic [R_W-1:0]   r_in;
    logic [R_W-1:0]   r_out;
    logic [B_W-1:0]   b_in;
    logic [B_W-1:0]   b_out;
    logic [CNT_W-1:0] bursts_q;
    logic             r_pop_last;

    assign r_in = {rid_i, rdata_i, rresp_i, rlast_i, ruser_i};
    assign b_in = {bid_i, bresp_i, buser_i};

    axi_response_slice_fifo #(.W(R_W)) u_r_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (r_in),
        .in_valid  (rvalid_i),
        .in_ready  (rready_o),
        .out_data  (r_out),
        .out_valid (rvalid_o),
        .out_ready (rready_i),
        .level     (r_level_o)
    );

    axi_response_slice_fifo #(.W(B_W)) u_b_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (b_in),
        .in_valid  (bvalid_i),
        .in_ready  (bready_o),
        .out_data  (b_out),
        .out_valid (bvalid_o),
        .out_ready (bready_i),
        .level     (b_level_o)
    );

    assign {rid_o, rdata_o, rresp_o, rlast_o, ruser_o} = r_out;
    assign {bid_o, bresp_o, buser_o}                   = b_out;

    assign r_pop_last = rvalid_o & rready_i & rlast_o;

    // Completed-burst counter: counts last beats accepted by the master, wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bursts_q <= '0;
        end else if (r_pop_last) begin
            bursts_q <= bursts_q + CNT_W'(1);
        end
    end

    assign r_bursts_o = bursts_q;

endmodule

// File: tb/tb_axi_response_slice.sv
// Self-checking bench for axi_response_slice: queue-based reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_axi_response_slice;

    localparam int unsigned DW = 64;
    localparam int unsigned IW = 16;
    localparam int unsigned UW = 6;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] rid_i = '0;
    logic [DW-1:0] rdata_i = '0;
    logic [1:0]    rresp_i = '0;
    logic          rlast_i = 1'b0;
    logic [UW-1:0] ruser_i = '0;
    logic          rvalid_i = 1'b0;
    logic          rready_o;
    logic [IW-1:0] bid_i = '0;
    logic [1:0]    bresp_i = '0;
    logic [UW-1:0] buser_i = '0;
    logic          bvalid_i = 1'b0;
    logic          bready_o;
    logic [IW-1:0] rid_o;
    logic [DW-1:0] rdata_o;
    logic [1:0]    rresp_o;
    logic          rlast_o;
    logic [UW-1:0] ruser_o;
    logic          rvalid_o;
    logic          rready_i = 1'b0;
    logic [IW-1:0] bid_o;
    logic [1:0]    bresp_o;
    logic [UW-1:0] buser_o;
    logic          bvalid_o;
    logic          bready_i = 1'b0;
    logic [1:0]    r_level_o;
    logic [1:0]    b_level_o;
    logic [CW-1:0] r_bursts_o;

    always #5 clk = ~clk;

    axi_response_slice #(
        .AXI_DATA_W (DW),
        .AXI_ID_IN  (IW),
        .AXI_USER_W (UW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rid_i      (rid_i),
        .rdata_i    (rdata_i),
        .rresp_i    (rresp_i),
        .rlast_i    (rlast_i),
        .ruser_i    (ruser_i),
        .rvalid_i   (rvalid_i),
        .rready_o   (rready_o),
        .bid_i      (bid_i),
        .bresp_i    (bresp_i),
        .buser_i    (buser_i),
        .bvalid_i   (bvalid_i),
        .bready_o   (bready_o),
        .rid_o      (rid_o),
        .rdata_o    (rdata_o),
        .rresp_o    (rresp_o),
        .rlast_o    (rlast_o),
        .ruser_o    (ruser_o),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .bid_o      (bid_o),
        .bresp_o    (bresp_o),
        .buser_o    (buser_o),
        .bvalid_o   (bvalid_o),
        .bready_i   (bready_i),
        .r_level_o  (r_level_o),
        .b_level_o  (b_level_o),
        .r_bursts_o (r_bursts_o)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [UW-1:0] user;
    } r_beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic [UW-1:0] user;
    } b_beat_t;

    r_beat_t       rq[$];
    b_beat_t       bq[$];
    logic [CW-1:0] m_bursts = '0;
    int            checks = 0;
    int            errors = 0;
    bit            chk_en = 1'b0;

    bit      m_rpush, m_rpop, m_bpush, m_bpop;
    r_beat_t m_rnew;
    b_beat_t m_bnew;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each channel is a queue of at most two beats
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq.delete();
            bq.delete();
            m_bursts = '0;
        end else begin
            m_rpop  = (rq.size() > 0) && rready_i;
            m_rpush = rvalid_i && (rq.size() < 2);
            m_rnew  = {rid_i, rdata_i, rresp_i, rlast_i, ruser_i};
            m_bpop  = (bq.size() > 0) && bready_i;
            m_bpush = bvalid_i && (bq.size() < 2);
            m_bnew  = {bid_i, bresp_i, buser_i};
            if (m_rpop) begin
                if (rq[0].last) m_bursts = m_bursts + 1'b1;
                void'(rq.pop_front());
            end
            if (m_rpush) rq.push_back(m_rnew);
            if (m_bpop) void'(bq.pop_front());
            if (m_bpush) bq.push_back(m_bnew);
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(posedge clk) begin
        #1;
        if (rst_n && chk_en) begin
            check("r_valid", 128'(rvalid_o), 128'(rq.size() != 0));
            check("r_ready", 128'(rready_o), 128'(rq.size() != 2));
            check("r_level", 128'(r_level_o), 128'(rq.size()));
            if (rq.size() > 0)
                check("r_head", 128'({rid_o, rdata_o, rresp_o, rlast_o, ruser_o}), 128'(rq[0]));
            check("b_valid", 128'(bvalid_o), 128'(bq.size() != 0));
            check("b_ready", 128'(bready_o), 128'(bq.size() != 2));
            check("b_level", 128'(b_level_o), 128'(bq.size()));
            if (bq.size() > 0)
                check("b_head", 128'({bid_o, bresp_o, buser_o}), 128'(bq[0]));
            check("r_bursts", 128'(r_bursts_o), 128'(m_bursts));
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rready", 128'(rready_o), 128'(1));
        check("rst_bready", 128'(bready_o), 128'(1));
        check("rst_rvalid", 128'(rvalid_o), 128'(0));
        check("rst_bvalid", 128'(bvalid_o), 128'(0));
        check("rst_bursts", 128'(r_bursts_o), 128'(0));
        check("rst_rlevel", 128'(r_level_o), 128'(0));
        check("rst_blevel", 128'(b_level_o), 128'(0));
        check("rst_rdata", 128'(rdata_o), 128'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Streaming 4-beat burst while B is held off by bready_i = 0
        rready_i = 1'b1;
        bvalid_i = 1'b1;
        bid_i    = 16'h00A3;
        bresp_i  = 2'b10;
        buser_i  = 6'h15;
        bready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rvalid_i = 1'b1;
            rid_i    = 16'h0005;
            rdata_i  = 64'(i);
            rlast_i  = (i == 4);
            step();
            check("stream_data", 128'(rdata_o), 128'(i));
            check("stream_id", 128'(rid_o), 128'(16'h0005));
            check("stream_level", 128'(r_level_o), 128'(1));
            check("b_hold_valid", 128'(bvalid_o), 128'(1));
            check("b_hold_id", 128'(bid_o), 128'(16'h00A3));
            check("b_hold_resp", 128'(bresp_o), 128'(2'b10));
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        step();
        check("stream_bursts", 128'(r_bursts_o), 128'(1));
        check("stream_drained", 128'(r_level_o), 128'(0));
        check("b_full", 128'(b_level_o), 128'(2));
        check("b_full_ready", 128'(bready_o), 128'(0));
        bvalid_i = 1'b0;
        bready_i = 1'b1;
        step();
        check("b_drain_id", 128'(bid_o), 128'(16'h00A3));
        step();
        check("b_drained", 128'(b_level_o), 128'(0));

        // Backpressure: three beats offered, two accepted, head held stable
        rready_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 64'h10;
        step();
        check("bp_level1", 128'(r_level_o), 128'(1));
        check("bp_ready1", 128'(rready_o), 128'(1));
        rdata_i = 64'h11;
        step();
        check("bp_level2", 128'(r_level_o), 128'(2));
        check("bp_ready2", 128'(rready_o), 128'(0));
        check("bp_head2", 128'(rdata_o), 128'(64'h10));
        rdata_i = 64'h12;
        step();
        check("bp_level3", 128'(r_level_o), 128'(2));
        check("bp_head3", 128'(rdata_o), 128'(64'h10));
        rvalid_i = 1'b0;
        rready_i = 1'b1;
        step();
        check("bp_release_ready", 128'(rready_o), 128'(1));
        check("bp_release_head", 128'(rdata_o), 128'(64'h11));
        step();
        check("bp_empty", 128'(rvalid_o), 128'(0));

        // Simultaneous push and pop at level 1
        rready_i = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = 64'h20;
        step();
        rready_i = 1'b1;
        rdata_i  = 64'h21;
        check("pp_old_head", 128'(rdata_o), 128'(64'h20));
        step();
        check("pp_level", 128'(r_level_o), 128'(1));
        check("pp_new_head", 128'(rdata_o), 128'(64'h21));
        rvalid_i = 1'b0;
        step();
        check("pp_empty", 128'(r_level_o), 128'(0));

        // Mid-operation reset with two beats buffered
        rready_i = 1'b0;
        rvalid_i = 1'b1;
        rlast_i  = 1'b1;
        rdata_i  = 64'h30;
        step();
        rdata_i = 64'h31;
        step();
        check("mr_level2", 128'(r_level_o), 128'(2));
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_rvalid", 128'(rvalid_o), 128'(0));
        check("mr_rready", 128'(rready_o), 128'(1));
        check("mr_bursts", 128'(r_bursts_o), 128'(0));
        check("mr_level", 128'(r_level_o), 128'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        rready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mr_no_stale", 128'(rvalid_o), 128'(0));
        end

        // Randomized traffic on both channels
        for (int i = 0; i < 3000; i++) begin
            rvalid_i = ($urandom_range(0, 3) != 0);
            rid_i    = 16'($urandom());
            rdata_i  = {$urandom(), $urandom()};
            rresp_i  = 2'($urandom());
            rlast_i  = ($urandom_range(0, 3) == 0);
            ruser_i  = 6'($urandom());
            rready_i = ($urandom_range(0, 9) < 7);
            bvalid_i = ($urandom_range(0, 1) != 0);
            bid_i    = 16'($urandom());
            bresp_i  = 2'($urandom());
            buser_i  = 6'($urandom());
            bready_i = ($urandom_range(0, 9) < 5);
            step();
        end

        // Drain
        rvalid_i = 1'b0;
        bvalid_i = 1'b0;
        rready_i = 1'b1;
        bready_i = 1'b1;
        step();
        step();
        step();
        check("final_rlevel", 128'(r_level_o), 128'(0));
        check("final_blevel", 128'(b_level_o), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
